// File: rtl/reg_write_sched_if.sv
// Bundle between the requesters, the register file and the write-port scheduler.
// Handshake: a requester raises req with stable addr/data and keeps them until gnt; gnt is same-cycle and the file commits at the next edge.
interface reg_write_sched_if #(
   parameter int PW = 4,
   parameter int DW = 8
);
   logic          ld_req;
   logic [PW-1:0] ld_addr;
   logic [DW-1:0] ld_data;
   logic          ld_gnt;
   logic          alu_req;
   logic [PW-1:0] alu_addr;
   logic [DW-1:0] alu_data;
   logic          alu_gnt;
   logic          mv_req;
   logic [PW-1:0] mv_src;
   logic [PW-1:0] mv_dst;
   logic          mv_busy;
   logic          mv_done;
   logic          rf_rd_sel;
   logic [PW-1:0] rf_rd_addr;
   logic [DW-1:0] rf_rd_data;
   logic          rf_wr_en;
   logic [PW-1:0] rf_wr_addr;
   logic [DW-1:0] rf_wr_data;
   logic [1:0]    mv_state;   // move FSM state for observation

   modport slave (
      input  ld_req, ld_addr, ld_data, alu_req, alu_addr, alu_data,
      input  mv_req, mv_src, mv_dst, rf_rd_data,
      output ld_gnt, alu_gnt, mv_busy, mv_done, rf_rd_sel, rf_rd_addr,
      output rf_wr_en, rf_wr_addr, rf_wr_data, mv_state
   );

   modport master (
      output ld_req, ld_addr, ld_data, alu_req, alu_addr, alu_data,
      output mv_req, mv_src, mv_dst, rf_rd_data,
      input  ld_gnt, alu_gnt, mv_busy, mv_done, rf_rd_sel, rf_rd_addr,
      input  rf_wr_en, rf_wr_addr, rf_wr_data, mv_state
   );
endinterface

// File: rtl/reg_write_sched.sv
// Single write-port arbiter for the register file: load, ALU and a register-move engine,
// with starvation counters that force-grant the ALU or a waiting move after MAX_WAIT denials.
module reg_write_sched #(
   parameter int PW       = 4,
   parameter int DW       = 8,
   parameter int MAX_WAIT = 4
) (
   input logic              clk,
   input logic              reset,
   reg_write_sched_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2
   } state_e;

   localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

   state_e        state_q, state_d;
   logic [PW-1:0] src_q, src_d;
   logic [PW-1:0] dst_q, dst_d;
   logic [DW-1:0] hold_q, hold_d;
   logic [3:0]    alu_cnt_q, alu_cnt_d;
   logic [3:0]    mv_cnt_q, mv_cnt_d;

   logic          mv_wr_req;
   logic          alu_force;
   logic          mv_force;
   logic          ld_gnt;
   logic          alu_gnt;
   logic          mv_gnt;
   logic          mv_done;
   logic          rd_sel;
   logic [PW-1:0] rd_addr;
   logic          wr_en;
   logic [PW-1:0] wr_addr;
   logic [DW-1:0] wr_data;

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      hold_d    = hold_q;
      alu_cnt_d = alu_cnt_q;
      mv_cnt_d  = mv_cnt_q;
      ld_gnt    = 1'b0;
      alu_gnt   = 1'b0;
      mv_gnt    = 1'b0;
      mv_done   = 1'b0;
      rd_sel    = 1'b0;
      rd_addr   = '0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;

      mv_wr_req = (state_q == S_WRITE);
      alu_force = bus.alu_req && (alu_cnt_q == MAX_WAIT_C);
      mv_force  = mv_wr_req && (mv_cnt_q == MAX_WAIT_C);

      // Grants are suppressed during reset so an aborted move never writes.
      if (!reset) begin
         if (alu_force)        alu_gnt = 1'b1;
         else if (mv_force)    mv_gnt  = 1'b1;
         else if (bus.ld_req)  ld_gnt  = 1'b1;
         else if (bus.alu_req) alu_gnt = 1'b1;
         else if (mv_wr_req)   mv_gnt  = 1'b1;
      end

      if (ld_gnt) begin
         wr_en   = 1'b1;
         wr_addr = bus.ld_addr;
         wr_data = bus.ld_data;
      end else if (alu_gnt) begin
         wr_en   = 1'b1;
         wr_addr = bus.alu_addr;
         wr_data = bus.alu_data;
      end else if (mv_gnt) begin
         wr_en   = 1'b1;
         wr_addr = dst_q;
         wr_data = hold_q;
      end

      // Counters saturate so a requester stays forced if an even higher one wins.
      if (!bus.alu_req || alu_gnt)     alu_cnt_d = '0;
      else if (alu_cnt_q != MAX_WAIT_C) alu_cnt_d = alu_cnt_q + 4'd1;

      if (!mv_wr_req || mv_gnt)        mv_cnt_d = '0;
      else if (mv_cnt_q != MAX_WAIT_C) mv_cnt_d = mv_cnt_q + 4'd1;

      case (state_q)
         S_IDLE: begin
            if (bus.mv_req) begin
               src_d   = bus.mv_src;
               dst_d   = bus.mv_dst;
               state_d = S_READ;
            end
         end
         S_READ: begin
            rd_sel  = 1'b1;
            rd_addr = src_q;
            hold_d  = bus.rf_rd_data;
            if (src_q == dst_q) begin
               mv_done = !reset;
               state_d = S_IDLE;
            end else begin
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            if (mv_gnt) begin
               mv_done = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         hold_q    <= '0;
         alu_cnt_q <= '0;
         mv_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         hold_q    <= hold_d;
         alu_cnt_q <= alu_cnt_d;
         mv_cnt_q  <= mv_cnt_d;
      end
   end

   assign bus.ld_gnt     = ld_gnt;
   assign bus.alu_gnt    = alu_gnt;
   assign bus.mv_busy    = (state_q != S_IDLE);
   assign bus.mv_done    = mv_done;
   assign bus.rf_rd_sel  = rd_sel;
   assign bus.rf_rd_addr = rd_addr;
   assign bus.rf_wr_en   = wr_en;
   assign bus.rf_wr_addr = wr_addr;
   assign bus.rf_wr_data = wr_data;
   assign bus.mv_state   = state_q;

endmodule
